// File: rtl/ray_intake_queue.sv
// ray_intake_queue: tags incoming rays with raster pixel coordinates and buffers them for the tracer.
// Defining RAY_INTAKE_STATS_EN adds the stall_cycles output.
module ray_intake_queue #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [12:0] image_width,
    input  logic [12:0] image_height,
    input  logic        in_valid,
    input  logic [31:0] in_dir_x,
    input  logic [31:0] in_dir_y,
    input  logic [31:0] in_dir_z,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_dir_x,
    output logic [31:0] out_dir_y,
    output logic [31:0] out_dir_z,
    output logic [12:0] out_pixel_x,
    output logic [12:0] out_pixel_y,
    output logic        out_last,
    output logic        busy,
    output logic        frame_done
`ifdef RAY_INTAKE_STATS_EN
    ,
    output logic [31:0] stall_cycles
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCEPT, DRAIN, DONE} state_t;
    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [12:0] px;
        logic [12:0] py;
        logic        last;
    } entry_t;

    state_t      state, state_nx;
    entry_t      mem [DEPTH];
    entry_t      head;
    logic [AW:0] wr_ptr, rd_ptr, occ;
    logic [25:0] total, accepted, product;
    logic [12:0] width, px, py;
    logic        full, empty, push, pop, last_tag, start_ok, row_end;

    assign product   = 26'(image_width) * 26'(image_height);
    assign occ       = wr_ptr - rd_ptr;
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready  = (state == ACCEPT) && !full;
    assign push      = in_valid && in_ready;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign last_tag  = accepted == total - 26'd1;
    assign start_ok  = start && (state == IDLE);
    assign row_end   = px == width - 13'd1;

    // Show-ahead head; gated so outputs read zero while the queue is empty.
    assign head        = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign out_dir_x   = head.x;
    assign out_dir_y   = head.y;
    assign out_dir_z   = head.z;
    assign out_pixel_x = head.px;
    assign out_pixel_y = head.py;
    assign out_last    = head.last;

    // Next-state and status outputs; DRAIN finishes on the edge that empties the queue.
    always_comb begin
        state_nx   = state;
        busy       = state != IDLE;
        frame_done = state == DONE;
        case (state)
            IDLE:    if (start) state_nx = (product == 26'd0) ? DONE : ACCEPT;
            ACCEPT:  if (push && last_tag) state_nx = DRAIN;
            DRAIN:   if (empty || (pop && occ == (AW+1)'(1))) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // State, FIFO pointers and raster counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            total    <= '0;
            accepted <= '0;
            width    <= '0;
            px       <= '0;
            py       <= '0;
        end else begin
            state <= state_nx;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (start_ok) begin
                width    <= image_width;
                total    <= product;
                accepted <= '0;
                px       <= '0;
                py       <= '0;
            end else if (push) begin
                accepted <= accepted + 26'd1;
                px       <= row_end ? 13'd0 : px + 13'd1;
                py       <= row_end ? py + 13'd1 : py;
            end
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{x: in_dir_x, y: in_dir_y, z: in_dir_z, px: px, py: py, last: last_tag};
    end

`ifdef RAY_INTAKE_STATS_EN
    // Saturating count of cycles the generator waited on a full queue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_cycles <= '0;
        else if (start_ok) stall_cycles <= '0;
        else if (state == ACCEPT && in_valid && !in_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_ray_intake_queue.sv
// tb_ray_intake_queue: directed, table-driven bench for ray_intake_queue.
module tb_ray_intake_queue;
    localparam int DEPTH = 8;

    logic        clk = 0, reset_n = 0, start = 0, in_valid = 0, out_ready = 0;
    logic [12:0] image_width = 0, image_height = 0;
    logic [31:0] in_dir_x = 0, in_dir_y = 0, in_dir_z = 0;
    logic        in_ready, out_valid, out_last, busy, frame_done;
    logic [31:0] out_dir_x, out_dir_y, out_dir_z;
    logic [12:0] out_pixel_x, out_pixel_y;
`ifdef RAY_INTAKE_STATS_EN
    logic [31:0] stall_cycles;
`endif

    ray_intake_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .image_width(image_width), .image_height(image_height),
        .in_valid(in_valid), .in_dir_x(in_dir_x), .in_dir_y(in_dir_y), .in_dir_z(in_dir_z),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_dir_x(out_dir_x), .out_dir_y(out_dir_y), .out_dir_z(out_dir_z),
        .out_pixel_x(out_pixel_x), .out_pixel_y(out_pixel_y), .out_last(out_last),
        .busy(busy), .frame_done(frame_done)
`ifdef RAY_INTAKE_STATS_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int w;
        int h;
        int low;
        int tgl;
        int restart;
    } frame_t;

    int          checks = 0, errors = 0;
    logic [95:0] q[$];
    int          seq = 0, pidx = 0, fd = 0, cyc = 0, last_pop_cyc = 0, pushes = 0;
    int          cur_w = 1, cur_n = 0;
    frame_t      tbl[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] dir_of(input int s);
        logic [31:0] u;
        u = s;
        return {u * 32'h9e3779b1, ~u, u + 32'h100};
    endfunction

    // Samples just after a negedge, scores pops and pushes, then advances one clock.
    task automatic tick();
        logic [95:0] e;
        #1;
        if (frame_done) begin
            fd++;
            if (cur_n > 0) chk("frame_done_after_last_pop", cyc - last_pop_cyc, 1);
        end
        if (out_valid && out_ready) begin
            if (pidx >= cur_n) chk("extra_pop", pidx + 1, cur_n);
            else if (q.size() == 0) chk("pop_empty", out_valid, 1'b0);
            else begin
                e = q.pop_front();
                chk("dir", {out_dir_x, out_dir_y, out_dir_z}, e);
                chk("pixel_x", out_pixel_x, pidx % cur_w);
                chk("pixel_y", out_pixel_y, pidx / cur_w);
                chk("last", out_last, pidx == cur_n - 1);
                pidx++;
                last_pop_cyc = cyc;
            end
        end
        if (in_valid && in_ready) begin
            q.push_back({in_dir_x, in_dir_y, in_dir_z});
            seq++;
            pushes++;
        end
        @(negedge clk);
        cyc++;
        {in_dir_x, in_dir_y, in_dir_z} = dir_of(seq);
    endtask

    task automatic begin_frame(input int w, input int h);
        cur_w = (w == 0) ? 1 : w;
        cur_n = w * h;
        pidx = 0;
        fd = 0;
        pushes = 0;
        q.delete();
        image_width = 13'(w);
        image_height = 13'(h);
        start = 1;
        in_valid = 1;
        out_ready = 0;
        tick();
        start = 0;
        image_width = 13'd7;
        image_height = 13'd9;
    endtask

    task automatic run_frame(input frame_t f);
        begin_frame(f.w, f.h);
        for (int c = 0; c < 4000 && fd == 0; c++) begin
            if (c == 0) chk("in_ready_after_start", in_ready, 1'b1);
            if (f.low >= DEPTH && c == f.low) begin
                chk("full_in_ready", in_ready, 1'b0);
                chk("pushes_when_full", pushes, DEPTH);
`ifdef RAY_INTAKE_STATS_EN
                chk("stall_cycles", stall_cycles, f.low - DEPTH);
`endif
            end
            if (f.low >= DEPTH && c == f.low + 1) chk("push_after_full_pop", in_ready, 1'b1);
            out_ready = (c >= f.low) && (f.tgl == 0 || c % 2 == 0);
            start = (c == f.restart);
            tick();
        end
        start = 0;
        chk("pops", pidx, cur_n);
        chk("frame_done_count", fd, 1);
        chk("busy_after_done", busy, 1'b0);
        out_ready = 1;
        repeat (3) begin
            chk("idle_in_ready", in_ready, 1'b0);
            tick();
        end
        chk("single_frame_done", fd, 1);
        in_valid = 0;
        out_ready = 0;
    endtask

    initial begin
        tbl[0] = '{w: 4,  h: 2, low: 0,  tgl: 0, restart: -1};
        tbl[1] = '{w: 16, h: 1, low: 12, tgl: 0, restart: -1};
        tbl[2] = '{w: 4,  h: 3, low: 0,  tgl: 0, restart: 3};
        tbl[3] = '{w: 1,  h: 1, low: 0,  tgl: 0, restart: -1};
        tbl[4] = '{w: 5,  h: 3, low: 0,  tgl: 1, restart: -1};
        tbl[5] = '{w: 13, h: 2, low: 3,  tgl: 1, restart: -1};
        {in_dir_x, in_dir_y, in_dir_z} = dir_of(seq);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_pixel", {out_pixel_x, out_pixel_y}, 26'd0);
        chk("rst_dir", {out_dir_x, out_dir_y, out_dir_z}, 96'd0);
`ifdef RAY_INTAKE_STATS_EN
        chk("rst_stall_cycles", stall_cycles, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1;

        for (int i = 0; i < 6; i++) run_frame(tbl[i]);

        for (int i = 0; i < 2; i++) begin
            begin_frame(i == 0 ? 0 : 5, i == 0 ? 5 : 0);
            out_ready = 1;
            repeat (4) begin
                chk("zero_in_ready", in_ready, 1'b0);
                tick();
            end
            chk("zero_frame_done", fd, 1);
            in_valid = 0;
        end

        begin_frame(4, 4);
        repeat (5) tick();
        chk("pushes_before_reset", pushes, 5);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_frame_done", frame_done, 1'b0);
        chk("mid_rst_pixel", {out_pixel_x, out_pixel_y, out_last}, 27'd0);
        chk("mid_rst_dir", {out_dir_x, out_dir_y, out_dir_z}, 96'd0);
        @(negedge clk);
        reset_n = 1;
        q.delete();
        fd = 0;
        out_ready = 1;
        repeat (3) begin
            chk("post_rst_out_valid", out_valid, 1'b0);
            tick();
        end
        chk("post_rst_no_frame_done", fd, 0);
        in_valid = 0;
        run_frame('{w: 4, h: 4, low: 0, tgl: 0, restart: -1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
